// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem read outstanding and
// presents registered {ins, pc, pc+4} to decode through a one-entry skid buffer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_ins,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } fetch_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx, req_pc, redirect_al;
  logic        drop, drop_nx;
  logic        skid_valid;
  fetch_t      skid;
  logic        issue, take, consume;

  // Request is gated by rst_n so it is low for the whole reset assertion.
  assign imem_req    = rst_n && (state == S_REQ) && !skid_valid;
  assign imem_addr   = pc;
  assign issue       = imem_req && imem_gnt;
  assign take        = (state == S_WAIT) && imem_rvalid && !drop && !redirect;
  assign consume     = out_valid && !stall;
  assign redirect_al = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    drop_nx  = drop;
    case (state)
      S_REQ: if (issue) begin
        state_nx = S_WAIT;
        pc_nx    = pc + 32'd4;
        drop_nx  = redirect;
      end
      S_WAIT: if (imem_rvalid) begin
        state_nx = S_REQ;
        drop_nx  = 1'b0;
      end else if (redirect) begin
        drop_nx  = 1'b1;
      end
      default: state_nx = S_REQ;
    endcase
    if (redirect) pc_nx = redirect_al;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      drop   <= 1'b0;
      req_pc <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      drop  <= drop_nx;
      if (issue) req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_ins      <= '0;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
      skid_valid   <= 1'b0;
      skid         <= '0;
    end else if (redirect) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (consume && skid_valid) begin
      // No request issues while the skid is full, so no response can coincide.
      out_ins      <= skid.ins;
      out_pc       <= skid.pc;
      out_pc_plus4 <= skid.pc + 32'd4;
      skid_valid   <= 1'b0;
    end else if (take && (!out_valid || !stall)) begin
      out_ins      <= imem_rdata;
      out_pc       <= req_pc;
      out_pc_plus4 <= req_pc + 32'd4;
      out_valid    <= 1'b1;
    end else if (take) begin
      skid       <= '{ins: imem_rdata, pc: req_pc};
      skid_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a latency-programmable imem model feeds the
// DUT, granted fetches are queued and compared as decode consumes them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_ins, out_pc, out_pc_plus4;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mpc = RST_PC;
  int          n_chk = 0, n_err = 0;
  int          lat = 1, cnt = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: score what the DUT shows now, then advance to posedge+1 and
  // drive the memory response for the new cycle.
  task automatic tick();
    logic        g;
    logic [31:0] ga;
    exp_t        e;
    g  = 1'b0;
    ga = imem_addr;
    if (rst_n) begin
      if (imem_req) chk("imem_addr", imem_addr, mpc);
      if (out_valid && !stall) begin
        if (q.size() == 0) chk("sb_empty", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_ins", out_ins, e.ins);
          chk("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
        end
      end
      g = imem_req && imem_gnt;
      if (redirect) begin
        q.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (g) begin
        q.push_back('{pc: mpc, ins: mem_data(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (g) begin pend = 1'b1; cnt = lat; paddr = ga; end
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data(paddr);
        pend        = 1'b0;
      end
    end
  endtask

  task automatic drain(input int n);
    imem_gnt = 1'b0;
    stall    = 1'b0;
    for (int i = 0; i < n; i++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_ins", out_ins, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc_plus4", out_pc_plus4, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);

    // First fetch and latency
    rst_n = 1'b1;
    #1;
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, RST_PC);
    imem_gnt = 1'b1;
    tick();
    chk("c1_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("c2_valid", {31'd0, out_valid}, 32'd1);
    chk("c2_pc", out_pc, RST_PC);
    chk("c2_addr", imem_addr, RST_PC + 32'd4);

    // Stall with skid: output held, third request blocked
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) chk("stall_hold_pc", out_pc, RST_PC);
      if (i >= 2) chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    drain(6);

    // Redirect in WAIT before rvalid (2-cycle memory)
    lat = 2;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect = 1'b0;
    chk("rd_wait_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rd_drop_valid", {31'd0, out_valid}, 32'd0);
    chk("rd_new_addr", imem_addr, 32'h0000_2000);
    lat = 1;
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick();
    chk("rd_first_pc", out_pc, 32'h0000_2000);

    // Redirect coincident with grant
    imem_gnt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_3000;
    tick();
    redirect = 1'b0;
    imem_gnt = 1'b0;
    chk("rg_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("rg_valid2", {31'd0, out_valid}, 32'd0);
    chk("rg_addr", imem_addr, 32'h0000_3000);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick();
    chk("rg_first_pc", out_pc, 32'h0000_3000);
    drain(4);

    // Misaligned redirect into the top word, then wrap
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick();
    chk("wr_pc", out_pc, 32'hFFFF_FFFC);
    chk("wr_pc_plus4", out_pc_plus4, 32'h0000_0000);
    chk("wr_next_addr", imem_addr, 32'h0000_0000);
    drain(4);

    // Async reset while stalled with the skid full
    stall = 1'b1;
    imem_gnt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("sk_full_no_req", {31'd0, imem_req}, 32'd0);
    chk("sk_full_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_ins", out_ins, 32'd0);
    chk("ar_pc", out_pc, 32'd0);
    chk("ar_pc_plus4", out_pc_plus4, 32'd0);
    chk("ar_req", {31'd0, imem_req}, 32'd0);
    q.delete();
    pend = 1'b0;
    imem_rvalid = 1'b0;
    mpc = RST_PC;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("ar_restart_req", {31'd0, imem_req}, 32'd1);
    chk("ar_restart_addr", imem_addr, RST_PC);
    stall = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    drain(6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
